// File: rtl/traffic_env_model.sv
// traffic_env_model: vehicle-side queue model closing the loop around a two-road traffic-light controller.
module traffic_env_chan #(
    parameter int CW        = 4,
    parameter int QMAX      = 15,
    parameter int DRAIN_CYC = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    i_l,
    input  logic          i_arr,
    output logic [CW-1:0] o_cnt,
    output logic          o_pass,
    output logic          o_drop
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} st_t;
    localparam logic [7:0] RLD = 8'(DRAIN_CYC - 1);
    st_t           w_st;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_tmr;
    logic          w_pass;
    logic          w_acc;
    always_comb begin
        w_st   = (r_cnt == '0) ? IDLE : (i_l == 2'b00) ? DRAIN : WAIT;
        w_pass = (w_st == DRAIN) && (r_tmr == 8'd0);
        w_acc  = i_arr && ((r_cnt < CW'(QMAX)) || w_pass);
    end
    // Leaving DRAIN for any reason, even for one yellow cycle, discards partial progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tmr  <= RLD;
            o_pass <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            r_cnt  <= r_cnt - CW'(w_pass) + CW'(w_acc);
            r_tmr  <= (w_st != DRAIN || w_pass) ? RLD : r_tmr - 8'd1;
            o_pass <= w_pass;
            o_drop <= i_arr && !w_acc;
        end
    end
    assign o_cnt = r_cnt;
endmodule

module traffic_env_model #(
    parameter int CW        = 4,
    parameter int QMAX      = 15,
    parameter int DRAIN_CYC = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    LA,
    input  logic [1:0]    LB,
    input  logic          arr_a,
    input  logic          arr_b,
    output logic          TA,
    output logic          TB,
    output logic [CW-1:0] count_a,
    output logic [CW-1:0] count_b,
    output logic          pass_a,
    output logic          pass_b,
    output logic          drop_a,
    output logic          drop_b,
    output logic          conflict,
    output logic          enc_err
);
    logic r_conf;
    logic r_enc;
    traffic_env_chan #(.CW(CW), .QMAX(QMAX), .DRAIN_CYC(DRAIN_CYC)) u_a (
        .clk(clk), .rst(rst), .i_l(LA), .i_arr(arr_a),
        .o_cnt(count_a), .o_pass(pass_a), .o_drop(drop_a)
    );
    traffic_env_chan #(.CW(CW), .QMAX(QMAX), .DRAIN_CYC(DRAIN_CYC)) u_b (
        .clk(clk), .rst(rst), .i_l(LB), .i_arr(arr_b),
        .o_cnt(count_b), .o_pass(pass_b), .o_drop(drop_b)
    );
    // Illegal encodings are treated as non-red for the conflict monitor.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_conf <= 1'b0;
            r_enc  <= 1'b0;
        end else begin
            r_conf <= r_conf | ((LA != 2'b10) && (LB != 2'b10));
            r_enc  <= r_enc | (LA == 2'b11) | (LB == 2'b11);
        end
    end
    assign TA       = (count_a != '0);
    assign TB       = (count_b != '0);
    assign conflict = r_conf;
    assign enc_err  = r_enc;
endmodule

// File: tb/tb_traffic_env_model.sv
// tb_traffic_env_model: directed and randomized checks against a progress-counting queue model.
module tb_traffic_env_model;
    localparam int CW = 4, QMAX = 15, DRAIN = 3;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    LA = 2'b10, LB = 2'b10;
    logic          arr_a = 1'b0, arr_b = 1'b0;
    logic          TA, TB, pass_a, pass_b, drop_a, drop_b, conflict, enc_err;
    logic [CW-1:0] count_a, count_b;
    logic [15:0]   obs;
    int            checks = 0, errors = 0;
    int            m_cnt [2], m_prog [2];
    bit            m_pass [2], m_drop [2];
    bit            m_conf, m_enc;

    traffic_env_model #(.CW(CW), .QMAX(QMAX), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .rst(rst), .LA(LA), .LB(LB), .arr_a(arr_a), .arr_b(arr_b),
        .TA(TA), .TB(TB), .count_a(count_a), .count_b(count_b),
        .pass_a(pass_a), .pass_b(pass_b), .drop_a(drop_a), .drop_b(drop_b),
        .conflict(conflict), .enc_err(enc_err)
    );

    always #5 clk = ~clk;
    assign obs = {TA, TB, count_a, count_b, pass_a, pass_b, drop_a, drop_b, conflict, enc_err};

    // A car leaves after DRAIN consecutive cycles of green with a non-empty queue.
    function automatic logic [15:0] expv();
        return {m_cnt[0] != 0, m_cnt[1] != 0, 4'(m_cnt[0]), 4'(m_cnt[1]),
                m_pass[0], m_pass[1], m_drop[0], m_drop[1], m_conf, m_enc};
    endfunction

    task automatic step(input bit r, input logic [1:0] la, input logic [1:0] lb, input bit aa, input bit ab);
        bit green, acc, a;
        logic [1:0] l;
        rst = r; LA = la; LB = lb; arr_a = aa; arr_b = ab;
        @(posedge clk);
        if (!r) begin
            m_cnt = '{0, 0}; m_prog = '{0, 0}; m_pass = '{0, 0}; m_drop = '{0, 0};
            m_conf = 0; m_enc = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                l = i ? lb : la;
                a = i ? ab : aa;
                green = (l == 2'b00) && (m_cnt[i] > 0);
                m_pass[i] = green && (m_prog[i] + 1 == DRAIN);
                m_prog[i] = (green && !m_pass[i]) ? m_prog[i] + 1 : 0;
                acc = a && (m_cnt[i] < QMAX || m_pass[i]);
                m_drop[i] = a && !acc;
                m_cnt[i] = m_cnt[i] + int'(acc) - int'(m_pass[i]);
            end
            m_conf = m_conf || (la != 2'b10 && lb != 2'b10);
            m_enc = m_enc || la == 2'b11 || lb == 2'b11;
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 2, 2, 0, 0);
        step(0, 2, 2, 0, 0);
        for (int c = 0; c < 10; c++) begin
            step(1, 2, 2, 0, 0);
            checks++;
            if (obs !== 16'h0) begin
                errors++;
                $display("FAIL reset cyc%0d: got %h expected 0000", c, obs);
            end
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 3; i++) begin
            step(1, 2, 2, 1, 0);
            checks++;
            if (count_a !== 4'(i) || TA !== 1'b1) begin
                errors++;
                $display("FAIL drain_fill%0d: count_a=%0d TA=%b expected %0d/1", i, count_a, TA, i);
            end
        end
        for (int c = 1; c <= 12; c++) begin
            step(1, 0, 2, 0, 0);
            checks++;
            if (pass_a !== (c == 3 || c == 6 || c == 9) || obs !== expv()) begin
                errors++;
                $display("FAIL drain_green%0d: pass_a=%b obs=%h expected %h", c, pass_a, obs, expv());
            end
        end
        checks++;
        if (count_a !== 4'd0 || TA !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: count_a=%0d TA=%b expected 0/0", count_a, TA);
        end
    endtask

    task automatic test_yellow();
        step(1, 2, 2, 0, 1);
        step(1, 2, 2, 0, 1);
        step(1, 2, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            step(1, 2, 1, 0, 0);
            checks++;
            if (pass_b !== 1'b0 || count_b !== 4'd2) begin
                errors++;
                $display("FAIL yellow%0d: pass_b=%b count_b=%0d expected 0/2", c, pass_b, count_b);
            end
        end
        for (int c = 1; c <= 6; c++) begin
            step(1, 2, 0, 0, 0);
            checks++;
            if (pass_b !== (c == 3 || c == 6) || obs !== expv()) begin
                errors++;
                $display("FAIL regreen%0d: pass_b=%b obs=%h expected %h", c, pass_b, obs, expv());
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 17; i++) begin
            step(1, 2, 2, 1, 0);
            checks++;
            if (count_a !== 4'(i > QMAX ? QMAX : i) || drop_a !== (i > QMAX)) begin
                errors++;
                $display("FAIL sat%0d: count_a=%0d drop_a=%b expected %0d/%b", i, count_a, drop_a,
                         i > QMAX ? QMAX : i, i > QMAX);
            end
        end
    endtask

    task automatic test_simul();
        step(1, 0, 2, 0, 0);
        step(1, 0, 2, 0, 0);
        step(1, 0, 2, 1, 0);
        checks++;
        if (pass_a !== 1'b1 || drop_a !== 1'b0 || count_a !== 4'd15) begin
            errors++;
            $display("FAIL simul: pass_a=%b drop_a=%b count_a=%0d expected 1/0/15", pass_a, drop_a, count_a);
        end
    endtask

    task automatic test_safety();
        step(1, 0, 1, 0, 0);
        checks++;
        if (conflict !== 1'b1 || enc_err !== 1'b0) begin
            errors++;
            $display("FAIL conflict: conflict=%b enc_err=%b expected 1/0", conflict, enc_err);
        end
        step(1, 0, 3, 0, 0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (conflict !== 1'b1 || enc_err !== 1'b1) begin
                errors++;
                $display("FAIL sticky%0d: conflict=%b enc_err=%b expected 1/1", c, conflict, enc_err);
            end
            step(1, 2, 2, 0, 0);
        end
        step(0, 2, 2, 0, 0);
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("FAIL safety_clear: got %h expected 0000", obs);
        end
    endtask

    task automatic test_random();
        logic [1:0] la = 2, lb = 2;
        step(0, 2, 2, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                la = 2'($urandom_range(0, 2));
                lb = (la != 2'b10) ? 2'b10 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 40) == 0) la = 2'b11;
                if ($urandom_range(0, 40) == 0) lb = 2'($urandom_range(0, 3));
            end
            step($urandom_range(0, 600) != 0, la, lb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random%0d: got %h expected %h", c, obs, expv());
            end
        end
    endtask

    initial begin
        m_cnt = '{0, 0}; m_prog = '{0, 0}; m_pass = '{0, 0}; m_drop = '{0, 0};
        m_conf = 0; m_enc = 0;
        #1;
        test_reset();
        test_drain();
        test_yellow();
        test_saturate();
        test_simul();
        test_safety();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_env_model.md
Name: traffic_env_model

Overview:
- Synthesizable model of the vehicle side of the two-road intersection: the opposite end of the traffic-light controller interface.
- Consumes the controller's light outputs LA/LB and the per-road car arrival pulses. Keeps a queue count per road and drains cars only on green.
- Drives the controller's sensor inputs TA/TB (cars waiting). Flags any safety violation in the lights it observes.
- Closes the loop in simulation and on-board demos without hand-written TA/TB stimulus.

Parameters:
- CW, 4, width of each queue counter.
- QMAX, 15, queue capacity per road. Constraint: 1 <= QMAX <= 2^CW-1.
- DRAIN_CYC, 3, cycles of continuous green per departing car. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- LA  in  2  road A light: 00 green, 01 yellow, 10 red, 11 illegal.
- LB  in  2  road B light, same encoding.
- arr_a  in  1  one car arrives on road A this cycle.
- arr_b  in  1  one car arrives on road B this cycle.
- TA  out  1  road A has cars waiting; equals (count_a != 0).
- TB  out  1  road B has cars waiting; equals (count_b != 0).
- count_a  out  CW  road A queue occupancy.
- count_b  out  CW  road B queue occupancy.
- pass_a  out  1  one-cycle pulse: a car left road A.
- pass_b  out  1  one-cycle pulse: a car left road B.
- drop_a  out  1  one-cycle pulse: road A arrival lost because the queue is full.
- drop_b  out  1  one-cycle pulse: road B arrival lost because the queue is full.
- conflict  out  1  sticky: both roads were non-red in the same cycle.
- enc_err  out  1  sticky: LA or LB was 11 in some cycle.

Behaviour:
- All state is updated on rising clk. rst=0 at an edge forces, at that edge: counts=0, TA=TB=0, pulses=0, conflict=0, enc_err=0, timers=DRAIN_CYC-1, FSMs=IDLE. This applies mid-operation as well.
- Roads A and B are independent, identical channels. Each channel FSM:
  - IDLE: count==0.
  - WAIT: count>0 and light not green.
  - DRAIN: count>0 and light green.
  - Transitions are evaluated on the registered count and the current light each cycle.
- Drain timer (8 bit), per channel:
  - Reloads to DRAIN_CYC-1 whenever the channel is not in DRAIN.
  - In DRAIN it decrements each cycle. At 0 it raises pass for that cycle, decrements count, and reloads.
  - Result: the first departure occurs DRAIN_CYC cycles after entering DRAIN.
  - Yellow, red and illegal all count as not green. The timer reload on yellow discards partial progress.
- Count update for each channel. "acc" means an arrival is accepted: arr=1 and (count<QMAX or pass).
  - pass only: count-1.
  - acc only: count+1.
  - Both: count unchanged, both pulses visible.
  - arr=1, count==QMAX, no pass: drop=1 for that cycle, count unchanged.
  - The count never exceeds QMAX and never underflows.
- TA/TB are derived from the registered counts. An arrival at edge k gives TA=1 after edge k; this is one-cycle latency from arr_a to TA.
- Safety monitors:
  - conflict is set at an edge where (LA!=10) and (LB!=10).
  - enc_err is set at an edge where LA==11 or LB==11.
  - Both stay set until reset. Illegal encodings also count as non-red for the conflict check.
- Inputs LA/LB/arr are sampled as synchronous signals; no synchronizers in this block.

Test Plan (default parameters unless stated):
1. Reset with rst=0 for 2 cycles, then rst=1, LA=LB=10, no arrivals -> all outputs 0 and count_a=count_b=0 for 10 cycles.
2. 3 arr_a pulses with LA=10, then LA=00 held -> count_a 1,2,3 and TA=1. pass_a fires 3, 6 and 9 cycles after the switch to green. count_a ends at 0 and TA=0 after the third pass.
3. count_b=2, LB=00 for 2 cycles, then LB=01 for 4 cycles, then LB=00 -> no pass_b during yellow. The first pass_b comes 3 cycles after green returns, confirming the timer reload.
4. 17 consecutive arr_a with LA=10 -> count_a saturates at 15. drop_a pulses on arrivals 16 and 17.
5. count_a=15, LA=00: arrival coinciding with the pass_a cycle -> pass_a=1, drop_a=0, count_a stays 15.
6. Drive LA=00, LB=01 for one cycle, then LB=11 for one cycle -> conflict=1 and enc_err=1, both held until rst=0; rst=0 then clears them and the queues.
